// File: rtl/div_pkg.sv
// Shared arithmetic-datapath definitions for the divider (and later the Booth multiplier).
package div_pkg;

  localparam int N_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/booth_divider_signed_mag.sv
// Combinational two's-complement to {sign, magnitude} converter.
// The magnitude is one bit wider so the most negative value is representable.
module signed_mag #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic             sign,
  output logic [WIDTH:0]   mag
);

  // Negate negative inputs; the extra MSB keeps -2^(WIDTH-1) exact.
  always_comb begin
    sign = value[WIDTH-1];
    if (sign) begin
      mag = {1'b0, ~value} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      mag = {1'b0, value};
    end
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor,
// quotient and remainder truncated toward zero, Start/Done handshake.
module booth_divider
  import div_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           Done,
  output logic           dz,
  output logic           ovf
);

  localparam int DW = 2 * N;
  localparam int MW = DW + 1;
  localparam int CW = $clog2(DW + 1);
  localparam logic [DW:0] Q_POS_MAX = MW'(2 ** (N - 1) - 1);
  localparam logic [DW:0] Q_NEG_MAX = MW'(2 ** (N - 1));

  div_state_t    state_r, state_nxt_s;
  logic          sd_r, sv_r;
  logic [DW:0]   dvd_mag_r;
  logic [N:0]    dvs_mag_r;
  logic [N+1:0]  prem_r;
  logic [CW-1:0] cnt_r;

  logic          dvd_sign_s, dvs_sign_s;
  logic [DW:0]   dvd_mag_s;
  logic [N:0]    dvs_mag_s;
  logic          accept_s, dz_s;
  logic [N+2:0]  shifted_s, trial_s;
  logic          q_bit_s;
  logic [N+1:0]  prem_nxt_s;
  logic          q_neg_s, ovf_s;
  logic [N-1:0]  q_fix_s, r_fix_s;

  signed_mag #(.WIDTH(DW)) u_dvd_mag (
    .value (dividend),
    .sign  (dvd_sign_s),
    .mag   (dvd_mag_s)
  );

  signed_mag #(.WIDTH(N)) u_dvs_mag (
    .value (divisor),
    .sign  (dvs_sign_s),
    .mag   (dvs_mag_s)
  );

  // Next-state logic; Start is only honoured in IDLE or DONE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    dz_s        = (divisor == {N{1'b0}});
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          accept_s    = 1'b1;
          state_nxt_s = dz_s ? DONE : CALC;
        end else begin
          state_nxt_s = state_r;
        end
      end
      CALC: begin
        if (cnt_r == CW'(1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // One unsigned restoring step plus the sign/overflow fix-up of the magnitudes.
  always_comb begin
    shifted_s = {prem_r, dvd_mag_r[DW-1]};
    trial_s   = shifted_s - {2'b00, dvs_mag_r};
    q_bit_s   = ~trial_s[N+2];
    if (q_bit_s) begin
      prem_nxt_s = trial_s[N+1:0];
    end else begin
      prem_nxt_s = shifted_s[N+1:0];
    end
    q_neg_s = sd_r ^ sv_r;
    if (q_neg_s) begin
      ovf_s   = (dvd_mag_r > Q_NEG_MAX);
      q_fix_s = ~dvd_mag_r[N-1:0] + N'(1);
    end else begin
      ovf_s   = (dvd_mag_r > Q_POS_MAX);
      q_fix_s = dvd_mag_r[N-1:0];
    end
    if (sd_r) begin
      r_fix_s = ~prem_r[N-1:0] + N'(1);
    end else begin
      r_fix_s = prem_r[N-1:0];
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sd_r      <= 1'b0;
      sv_r      <= 1'b0;
      dvd_mag_r <= {MW{1'b0}};
      dvs_mag_r <= {(N + 1){1'b0}};
      prem_r    <= {(N + 2){1'b0}};
      cnt_r     <= {CW{1'b0}};
      quotient  <= {N{1'b0}};
      remainder <= {N{1'b0}};
      Done      <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            sd_r      <= dvd_sign_s;
            sv_r      <= dvs_sign_s;
            dvd_mag_r <= dvd_mag_s;
            dvs_mag_r <= dvs_mag_s;
            prem_r    <= {(N + 2){1'b0}};
            cnt_r     <= CW'(DW);
            ovf       <= 1'b0;
            dz        <= dz_s;
            if (dz_s) begin
              quotient  <= {N{1'b0}};
              remainder <= {N{1'b0}};
              Done      <= 1'b1;
            end else begin
              Done <= 1'b0;
            end
          end
        end
        CALC: begin
          // Bit DW of the magnitude is always 0 and is held; the quotient grows from the LSB.
          prem_r    <= prem_nxt_s;
          dvd_mag_r <= {dvd_mag_r[DW], dvd_mag_r[DW-2:0], q_bit_s};
          cnt_r     <= cnt_r - CW'(1);
        end
        FIX: begin
          ovf  <= ovf_s;
          Done <= 1'b1;
          if (ovf_s) begin
            quotient  <= {N{1'b0}};
            remainder <= {N{1'b0}};
          end else begin
            quotient  <= q_fix_s;
            remainder <= r_fix_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed and random bench for booth_divider against an integer-arithmetic reference.
module tb_booth_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic [5:0]  quotient;
  logic [5:0]  remainder;
  logic        Done;
  logic        dz;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  booth_divider #(.N(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .Done      (Done),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain signed division, truncating toward zero.
  task automatic model(input int a, input int b, output logic [5:0] q, output logic [5:0] r,
                       output logic z, output logic o);
    int qi, ri;
    z = 1'b0; o = 1'b0; q = 6'd0; r = 6'd0;
    if (b == 0) begin
      z = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
      if (qi < -32 || qi > 31) begin
        o = 1'b1;
      end else begin
        q = qi[5:0];
        r = ri[5:0];
      end
    end
  endtask

  task automatic run_div(input int a, input int b, input bit poke);
    logic [5:0] eq, er;
    logic ez, eo;
    int lat;
    model(a, b, eq, er, ez, eo);
    @(negedge clk);
    dividend = a[11:0];
    divisor  = b[5:0];
    Start    = 1'b1;
    @(posedge clk); #1;
    Start    = 1'b0;
    dividend = 12'($urandom);
    divisor  = 6'($urandom);
    if (!ez) chk("done_drop", 32'(Done), 32'd0);
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 3) begin
        Start    = 1'b1;
        dividend = 12'd77;
        divisor  = 6'd3;
      end else if (poke && lat == 4) begin
        Start = 1'b0;
      end
    end
    chk("latency", 32'(lat), ez ? 32'd0 : 32'd13);
    chk("done", 32'(Done), 32'd1);
    chk("dz", 32'(dz), 32'(ez));
    chk("ovf", 32'(ovf), 32'(eo));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
  endtask

  initial begin
    logic signed [11:0] ra;
    logic signed [5:0]  rb;
    rst = 1'b1; Start = 1'b0; dividend = 12'd0; divisor = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_div(-143, 11, 1'b0);
    run_div(31, 6, 1'b0);
    run_div(-181, -12, 1'b0);

    // Reset during the 5th CALC cycle of an in-flight division.
    @(negedge clk);
    dividend = 12'd50; divisor = 6'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    chk("mid_rst_dz", 32'(dz), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    repeat (16) @(posedge clk);
    #1;
    chk("idle_hold", 32'(Done), 32'd0);

    run_div(-64, 2, 1'b0);
    run_div(64, 2, 1'b0);
    run_div(-2048, -32, 1'b0);
    run_div(100, 0, 1'b0);
    run_div(180, -12, 1'b1);
    run_div(30, 6, 1'b0);
    run_div(30, -7, 1'b0);
    run_div(2047, 31, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = 12'($urandom);
      rb = 6'($urandom);
      if (i % 2 == 0) ra = 12'(int'(ra) % 700);
      run_div(int'(ra), int'(rb), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
